// File: rtl/qn_event_pkg.sv
// Shared constants, layer codes and FSM state type for the event word serializer.
package qn_event_pkg;

    localparam int unsigned NTUBES = 32;
    localparam int unsigned TW     = 8;
    localparam int unsigned EVW    = NTUBES * TW;

    localparam logic [4:0] HDR_TAG  = 5'b11100;
    localparam logic [4:0] LAYER_3A = 5'b11000;
    localparam logic [4:0] LAYER_3B = 5'b11001;
    localparam logic [4:0] LAYER_4A = 5'b00100;
    localparam logic [4:0] LAYER_4B = 5'b00101;

    localparam logic [TW-1:0] NOHIT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        EMIT,
        DONE
    } ser_state_t;

    // Tubes come in groups of eight per layer, in event order 3A, 3B, 4A, 4B.
    function automatic logic [4:0] layer_code(input logic [1:0] grp);
        case (grp)
            2'd0:    layer_code = LAYER_3A;
            2'd1:    layer_code = LAYER_3B;
            2'd2:    layer_code = LAYER_4A;
            default: layer_code = LAYER_4B;
        endcase
    endfunction

endpackage

// File: rtl/tube_word_fmt.sv
// Combinational formatter: selects tube idx from the latched event and builds
// its tagged 16-bit word {layer_code, tube-in-layer, drift time}.
module tube_word_fmt
    import qn_event_pkg::*;
(
    input  logic [4:0]     idx,
    input  logic [EVW-1:0] shadow,
    output logic [15:0]    word
);

    logic [TW-1:0] tube_time;

    // Tube 0 sits in the most significant byte of the event.
    always_comb begin
        tube_time = '0;
        for (int unsigned k = 0; k < NTUBES; k++) begin
            if (idx == 5'(k))
                tube_time = shadow[EVW-1-TW*k -: TW];
        end
        word = {layer_code(idx[4:3]), idx[2:0], tube_time};
    end

endmodule

// File: rtl/event_word_serializer.sv
// Pops one 256-bit event and writes a header plus 32 tube words to the output FIFO,
// honouring word_afull. Define SERIALIZER_SKIP_NOHIT_EN to drop 8'hFF (no-hit) tubes.
module event_word_serializer
    import qn_event_pkg::*;
(
    input  logic           clk100,
    input  logic           rst,
    input  logic [EVW-1:0] ev_data,
    input  logic           ev_empty,
    output logic           ev_rd_en,
    input  logic           word_afull,
    output logic           word_wr_en,
    output logic [15:0]    word_data,
    output logic           busy,
    output logic [7:0]     seq
);

    ser_state_t     state;
    logic [4:0]     idx;
    logic [EVW-1:0] shadow;
    logic [15:0]    tube_word;
    logic [7:0]     seq_next;
    logic           last_tube;

    assign seq_next  = seq + 8'd1;
    assign last_tube = (idx == 5'(NTUBES - 1));

    tube_word_fmt u_fmt (
        .idx    (idx),
        .shadow (shadow),
        .word   (tube_word)
    );

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '1;
            ev_rd_en   <= 1'b0;
            word_wr_en <= 1'b0;
            word_data  <= '0;
            busy       <= 1'b0;
            seq        <= '0;
        end else begin
            ev_rd_en   <= 1'b0;
            word_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ev_empty) begin
                        shadow   <= ev_data;
                        ev_rd_en <= 1'b1;
                        busy     <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (!word_afull) begin
                        word_wr_en <= 1'b1;
                        word_data  <= {HDR_TAG, 3'b000, seq_next};
                        idx        <= '0;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
`ifdef SERIALIZER_SKIP_NOHIT_EN
                    // No-hit tubes are skipped without waiting on backpressure.
                    if (tube_word[TW-1:0] == NOHIT || !word_afull) begin
                        if (tube_word[TW-1:0] != NOHIT) begin
                            word_wr_en <= 1'b1;
                            word_data  <= tube_word;
                        end
                        if (last_tube)
                            state <= DONE;
                        else
                            idx <= idx + 5'd1;
                    end
`else
                    if (!word_afull) begin
                        word_wr_en <= 1'b1;
                        word_data  <= tube_word;
                        if (last_tube)
                            state <= DONE;
                        else
                            idx <= idx + 5'd1;
                    end
`endif
                end
                DONE: begin
                    seq   <= seq_next;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
